// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: streams program words from a host into memory while holding the CPU in
// reset, then releases the CPU once every word has been written.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   load_start          one-cycle load request; load_base/load_count sampled with it
//   abort               cancels a load in progress (LOAD or DRAIN only)
//   host_valid/ready    host word handshake, host_data carries the word
//   mem_we/addr/wdata/be registered memory write port, one word per cycle
//   cpu_reset           high except in RUN
//   load_done/load_err  sticky status of the most recent request
module prog_load_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [ADDR_W-1:0]   load_base,
    input  logic [CNT_W-1:0]    load_count,
    input  logic                abort,
    input  logic                host_valid,
    input  logic [DATA_W-1:0]   host_data,
    output logic                host_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);
    localparam logic [PTR_W:0]    OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StRun} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    occ_q;
    logic [CNT_W-1:0]  count_q, accepted_q, written_q;
    logic [ADDR_W-1:0] addr_next_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done_q, err_q;

    logic fifo_full, fifo_empty, in_xfer, do_abort, start_ev, start_zero, start_big;
    logic push, pop;

    assign fifo_full  = (occ_q == OCC_FULL);
    assign fifo_empty = (occ_q == '0);
    assign in_xfer    = (state_q == StLoad) || (state_q == StDrain);
    assign do_abort   = abort && in_xfer;
    // RUN re-enters the IDLE start handling directly
    assign start_ev   = load_start && ((state_q == StIdle) || (state_q == StRun));
    assign start_zero = (load_count == '0);
    assign start_big  = (load_count > MAX_CNT);
    assign push       = host_valid && host_ready && !do_abort;
    // Pop is based on current occupancy, so a word pushed this cycle pops next cycle
    assign pop        = in_xfer && !fifo_empty && !abort;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun: begin
                if (load_start) begin
                    if (start_big)       state_d = StIdle;
                    else if (start_zero) state_d = StRun;
                    else                 state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (host_valid && host_ready &&
                             (accepted_q + CNT_W'(1)) == count_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (fifo_empty && written_q == count_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        cpu_reset  = (state_q != StRun);
        host_ready = (state_q == StLoad) && !fifo_full && (accepted_q < count_q);
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        mem_be     = {BYTES{mem_we_q}};
        load_done  = done_q;
        load_err   = err_q;
    end

    // FIFO storage needs no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= host_data;
        end
    end

    // Datapath: counters, FIFO pointers, registered write port, status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            count_q     <= '0;
            accepted_q  <= '0;
            written_q   <= '0;
            addr_next_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (start_ev) begin
                count_q     <= load_count;
                accepted_q  <= '0;
                written_q   <= '0;
                addr_next_q <= load_base;
                done_q      <= start_zero;
                err_q       <= start_big;
            end
            if (do_abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                err_q    <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                    accepted_q <= accepted_q + CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                    written_q   <= written_q + CNT_W'(1);
                    addr_next_q <= addr_next_q + ADDR_STEP;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= addr_next_q;
                    mem_wdata_q <= fifo_mem[rd_ptr_q];
                end
                if (push && !pop)      occ_q <= occ_q + (PTR_W + 1)'(1);
                else if (pop && !push) occ_q <= occ_q - (PTR_W + 1)'(1);
            end
            if (state_q == StDrain && state_d == StRun) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized bench for prog_load_ctrl with a scoreboard of expected memory writes built from
// the host handshakes the bench itself drives.
module tb_prog_load_ctrl;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [31:0] load_base;
    logic [15:0] load_count;
    logic        abort;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    prog_load_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .load_count (load_count),
        .abort      (abort),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;
    int nwr   = 0;
    int last_we = -1;
    int cur_cnt = 0;
    logic [31:0] cur_base = '0;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Records the handshake the host is about to complete, advances one clock, then checks
    // any write against the scoreboard.
    task automatic step();
        logic [63:0] e;
        if (host_valid && host_ready) begin
            check("ready_cnt", 64'(acc < cur_cnt), 1);
            exp_q.push_back({cur_base + 32'(acc) * 32'd4, host_data});
            acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(mem_we), 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
                check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
            nwr++;
            last_we = cyc;
        end
        check("mem_be", 64'(mem_be), {60'b0, {4{mem_we}}});
        check("fifo_occ", 64'((acc - nwr) <= FIFO_DEPTH), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 64'(mem_we), 0);
        check({tag, "_addr"}, 64'(mem_addr), 0);
        check({tag, "_wdata"}, 64'(mem_wdata), 0);
        check({tag, "_be"}, 64'(mem_be), 0);
        check({tag, "_cpurst"}, 64'(cpu_reset), 1);
        check({tag, "_ready"}, 64'(host_ready), 0);
        check({tag, "_done"}, 64'(load_done), 0);
        check({tag, "_err"}, 64'(load_err), 0);
    endtask

    task automatic start(input logic [31:0] base, input int count);
        cur_base   = base;
        cur_cnt    = count;
        acc        = 0;
        nwr        = 0;
        host_valid = 1'b0;
        load_start = 1'b1;
        load_base  = base;
        load_count = 16'(count);
        step();
        load_start = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] base, input int count, input int pct);
        int n = 0;
        start(base, count);
        check("start_cpu_rst", 64'(cpu_reset), 1);
        check("start_done_clr", 64'(load_done), 0);
        while (!load_done && n < 400) begin
            host_valid = ($urandom_range(0, 99) < pct);
            host_data  = $urandom;
            step();
            if (!load_done) check("load_cpu_rst", 64'(cpu_reset), 1);
            n++;
        end
        host_valid = 1'b0;
        check("load_done", 64'(load_done), 1);
        check("load_err", 64'(load_err), 0);
        check("run_cpu_rst", 64'(cpu_reset), 0);
        check("n_writes", 64'(nwr), 64'(count));
        check("sb_empty", 64'(exp_q.size()), 0);
        check("done_after_we", 64'(last_we < cyc), 1);
        step();
        check("run_no_we", 64'(mem_we), 0);
        check("run_ready", 64'(host_ready), 0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        abort      = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        step();
        check("idle_cpu_rst", 64'(cpu_reset), 1);

        // Basic load, host always valid
        run_load(32'h0000_1000, 3, 100);
        // Address wrap
        run_load(32'hFFFF_FFFC, 2, 100);
        // Host gaps with the FIFO partly filled
        run_load(32'h0000_2000, 8, 40);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] b;
            b = (i % 2 == 0) ? ($urandom & 32'hFFFF_FFFC) : (32'hFFFF_FFF0 | ($urandom & 32'hC));
            run_load(b, $urandom_range(1, 12), (i % 3 == 0) ? 100 : $urandom_range(20, 80));
        end

        // Over-length request is rejected in place
        start(32'h0000_3000, 1025);
        check("big_err", 64'(load_err), 1);
        check("big_done", 64'(load_done), 0);
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_data  = $urandom;
            check("big_cpu_rst", 64'(cpu_reset), 1);
            check("big_ready", 64'(host_ready), 0);
            step();
            check("big_no_we", 64'(mem_we), 0);
        end
        host_valid = 1'b0;

        // Abort after two accepted words
        start(32'h0000_4000, 5);
        n = 0;
        while (acc < 2 && n < 50) begin
            host_valid = 1'b1;
            host_data  = $urandom;
            step();
            n++;
        end
        host_valid = 1'b0;
        exp_q.delete();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_we", 64'(mem_we), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_we", 64'(mem_we), 0);
        end
        check("abort_nwr", 64'(nwr <= 2), 1);
        check("abort_err", 64'(load_err), 1);
        check("abort_cpu_rst", 64'(cpu_reset), 1);
        check("abort_ready", 64'(host_ready), 0);
        check("abort_done", 64'(load_done), 0);
        run_load(32'h0000_5000, 1, 100);

        // Reset pulse while draining
        start(32'h0000_6000, 4);
        n = 0;
        while (acc < 4 && n < 50) begin
            host_valid = 1'b1;
            host_data  = $urandom;
            step();
            n++;
        end
        host_valid = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        step();
        step();
        reset = 1'b0;
        acc = 0;
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_we", 64'(mem_we), 0);
            check("post_rst_cpu", 64'(cpu_reset), 1);
        end

        // Zero-length load goes straight to RUN, then a new load from RUN
        start(32'h0000_7000, 0);
        check("zero_done", 64'(load_done), 1);
        check("zero_cpu_rst", 64'(cpu_reset), 0);
        check("zero_err", 64'(load_err), 0);
        run_load(32'h0000_8000, 2, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, staging FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_WORDS, default 1024, largest permitted load length.
REQ-005 SHALL have parameter CNT_W, default 16, width of the word-count fields.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 load_start  input  1  one-cycle request to begin a load.
REQ-009 load_base  input  ADDR_W  byte address of the first word, sampled with load_start.
REQ-010 load_count  input  CNT_W  number of words to load, sampled with load_start.
REQ-011 abort  input  1  cancels an in-progress load.
REQ-012 host_valid  input  1  host_data holds a valid word.
REQ-013 host_data  input  DATA_W  program word from the host.
REQ-014 host_ready  output  1  controller accepts host_data this cycle.
REQ-015 mem_we  output  1  memory write strobe, one word per cycle.
REQ-016 mem_addr  output  ADDR_W  byte address of the write.
REQ-017 mem_wdata  output  DATA_W  write data.
REQ-018 mem_be  output  DATA_W/8  byte enables, all ones whenever mem_we=1, else zero.
REQ-019 cpu_reset  output  1  holds the CPU core in reset.
REQ-020 load_done  output  1  level, last load completed successfully.
REQ-021 load_err  output  1  level, last request rejected or aborted.

Function
REQ-022 SHALL implement an FSM with states IDLE, LOAD, DRAIN and RUN, all registered.
REQ-023 IDLE: cpu_reset=1 and host_ready=0; on load_start, latch base and count, clear load_done and load_err.
REQ-024 IDLE with load_start and load_count==0 SHALL go to RUN directly and set load_done.
REQ-025 IDLE with load_start and load_count>MAX_WORDS SHALL set load_err and remain in IDLE.
REQ-026 For any other load_start in IDLE, the FSM SHALL go to LOAD.
REQ-027 LOAD: host_ready = FIFO not full AND accepted<count; a word transfers only when host_valid and host_ready are both 1.
REQ-028 Transition to DRAIN SHALL occur in the cycle after the count-th word is accepted.
REQ-029 The FIFO SHALL pop one entry per cycle whenever it is non-empty, in LOAD and in DRAIN.
REQ-030 A word accepted in cycle N SHALL appear with mem_we=1 no earlier than cycle N+1 (registered outputs).
REQ-031 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-032 Push on full or pop on empty SHALL never occur.
REQ-033 The k-th written word (k from 0) SHALL have mem_addr = load_base + k*(DATA_W/8), modulo 2^ADDR_W (wrap, no error).
REQ-034 Words SHALL be written in acceptance order, with no loss or duplication.
REQ-035 DRAIN to RUN SHALL occur when the FIFO is empty and written==count; load_done is set on entry to RUN.
REQ-036 RUN: cpu_reset=0, host_ready=0, mem_we=0.
REQ-037 load_start in RUN SHALL re-enter IDLE-start handling in the same edge, so cpu_reset=1 from the next cycle.
REQ-038 abort in LOAD or DRAIN SHALL go to IDLE, flush the FIFO, suppress mem_we from the next cycle, and set load_err.
REQ-039 abort in IDLE or RUN SHALL be ignored.
REQ-040 If abort and load_start are asserted in the same cycle, abort wins.
REQ-041 load_start in LOAD or DRAIN SHALL be ignored.

Reset
REQ-042 reset SHALL asynchronously force: state=IDLE, FIFO empty, counters=0, cpu_reset=1, host_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, load_done=0, load_err=0.
REQ-043 reset asserted mid-load SHALL discard all pending words, with no further mem_we after the asserting edge.

Verification
REQ-044 Base 0x0000_1000, count 3, host_valid held high, words A,B,C -> writes at 0x1000, 0x1004, 0x1008; load_done=1; cpu_reset falls after the last write.
REQ-045 Count 8, FIFO_DEPTH 4, memory pop stalled by host gaps, random host_valid -> 8 in-order writes; host_ready never asserted with count reached; FIFO never overflows.
REQ-046 Count 1025 -> load_err=1, state stays IDLE, no mem_we, cpu_reset=1.
REQ-047 Base 0xFFFF_FFFC, count 2 -> writes at 0xFFFF_FFFC and 0x0000_0000.
REQ-048 Abort after 2 of 5 words -> at most 2 writes, load_err=1, IDLE; a subsequent count-1 load succeeds.
REQ-049 Reset pulse during DRAIN -> all outputs at reset values immediately; no writes afterwards; load_start in RUN re-asserts cpu_reset next cycle.
